// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: latch enables/flushes, load-use, memory-wait, branch and halt handling, plus MEM->EX forwarding.
// Define HAZARD_STATS_EN to add stall/flush/load-stall counters.
module hazard_ctrl #(
   parameter int REGW  = 5,
   parameter int WORDW = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [REGW-1:0]  id_rs,
   input  logic [REGW-1:0]  id_rt,
   input  logic [REGW-1:0]  ex_rs,
   input  logic [REGW-1:0]  ex_rt,
   input  logic [REGW-1:0]  ex_regDst,
   input  logic             ex_dREN,
   input  logic [REGW-1:0]  mem_regDst,
   input  logic             mem_regWr,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic [WORDW-1:0] mem_wdat,
   input  logic             br_taken,
   input  logic             ex_halt,
   output logic             pcen,
   output logic             ifen,
   output logic             if_flush,
   output logic             exen,
   output logic             flush,
   output logic             memen,
   output logic             srcA,
   output logic             srcB,
   output logic [WORDW-1:0] forData,
`ifdef HAZARD_STATS_EN
   output logic [31:0]      stall_cnt,
   output logic [31:0]      flush_cnt,
   output logic [31:0]      load_stall_cnt,
`endif
   output logic             halted
);

   typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT, HALT} state_t;

   typedef struct packed {
      logic pcen;
      logic ifen;
      logic if_flush;
      logic exen;
      logic flush;
      logic memen;
   } ctrl_t;

   state_t state, state_nxt;
   ctrl_t  ctrl;
   logic   init;
   logic   halted_c;
   logic   memwait, halt_req, br_req, lu_req;
   logic   br_fire, lu_fire;

   assign memwait  = (mem_dREN | mem_dWEN) & ~dhit;
   assign halt_req = ex_halt & ihit;
   assign br_req   = br_taken & ihit;
   assign lu_req   = ex_dREN & (|ex_regDst) &
                     ((ex_regDst == id_rs) | (ex_regDst == id_rt)) & ihit;

   // Resolved events after priority; used by the stats counters.
   assign br_fire = ~init & (state == RUN) & ~memwait & ~halt_req & br_req;
   assign lu_fire = ~init & (state == RUN) & ~memwait & ~halt_req & ~br_req & lu_req;

   // init holds the reset output pattern until the first edge after release.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
         init  <= 1'b1;
      end else begin
         init  <= 1'b0;
         state <= init ? RUN : state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (memwait)       state_nxt = MEMWAIT;
            else if (halt_req) state_nxt = HALT;
            else if (br_req)   state_nxt = RUN;
            else if (lu_req)   state_nxt = LDSTALL;
         end
         LDSTALL: state_nxt = memwait ? MEMWAIT : RUN;
         MEMWAIT: if (!memwait) state_nxt = RUN;
         HALT:    state_nxt = HALT;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      ctrl     = '{pcen: ihit, ifen: ihit, if_flush: 1'b0,
                   exen: ihit, flush: 1'b0, memen: ihit};
      halted_c = 1'b0;
      if (init) begin
         ctrl = '{pcen: 1'b0, ifen: 1'b0, if_flush: 1'b1,
                  exen: 1'b0, flush: 1'b1, memen: 1'b0};
      end else begin
         case (state)
            RUN: begin
               if (memwait) begin
                  ctrl = '0;
               end else if (halt_req) begin
                  // Let the halt drain into memory, freeze everything else.
                  ctrl       = '0;
                  ctrl.memen = 1'b1;
               end else if (br_req) begin
                  ctrl.if_flush = 1'b1;
                  ctrl.flush    = 1'b1;
               end else if (lu_req) begin
                  ctrl.pcen  = 1'b0;
                  ctrl.ifen  = 1'b0;
                  ctrl.flush = 1'b1;
               end
            end
            LDSTALL: if (memwait) ctrl = '0;
            MEMWAIT: if (memwait) ctrl = '0;
            HALT: begin
               ctrl     = '0;
               halted_c = 1'b1;
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign pcen     = ctrl.pcen;
   assign ifen     = ctrl.ifen;
   assign if_flush = ctrl.if_flush;
   assign exen     = ctrl.exen;
   assign flush    = ctrl.flush;
   assign memen    = ctrl.memen;
   assign halted   = halted_c;

   // Stores and r0 writes never forward.
   logic fwd_ok;
   assign fwd_ok  = ~init & mem_regWr & ~mem_dWEN & (|mem_regDst);
   assign srcA    = fwd_ok & (mem_regDst == ex_rs);
   assign srcB    = fwd_ok & (mem_regDst == ex_rt);
   assign forData = (srcA | srcB) ? mem_wdat : '0;

`ifdef HAZARD_STATS_EN
   logic cnt_en;
   assign cnt_en = ~init & (state != HALT);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt      <= '0;
         flush_cnt      <= '0;
         load_stall_cnt <= '0;
      end else if (cnt_en) begin
         if (state == LDSTALL || state == MEMWAIT) stall_cnt <= stall_cnt + 32'd1;
         if (br_fire) flush_cnt      <= flush_cnt + 32'd1;
         if (lu_fire) load_stall_cnt <= load_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; checks {pcen,ifen,if_flush,exen,flush,memen}, halted and forwarding.
// Counter checks compile in only when HAZARD_STATS_EN is defined.
module tb_hazard_ctrl;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit, dhit;
   logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_regDst, mem_regDst;
   logic        ex_dREN, mem_regWr, mem_dREN, mem_dWEN;
   logic [31:0] mem_wdat, forData;
   logic        br_taken, ex_halt;
   logic        pcen, ifen, if_flush, exen, flush, memen, srcA, srcB, halted;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, flush_cnt, load_stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   hazard_ctrl #(.REGW(5), .WORDW(32)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_regDst(ex_regDst), .ex_dREN(ex_dREN),
      .mem_regDst(mem_regDst), .mem_regWr(mem_regWr),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_wdat(mem_wdat),
      .br_taken(br_taken), .ex_halt(ex_halt),
      .pcen(pcen), .ifen(ifen), .if_flush(if_flush), .exen(exen),
      .flush(flush), .memen(memen), .srcA(srcA), .srcB(srcB),
      .forData(forData),
`ifdef HAZARD_STATS_EN
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .load_stall_cnt(load_stall_cnt),
`endif
      .halted(halted)
   );

   always #5 CLK = ~CLK;

   logic [5:0] ctrl_v;
   assign ctrl_v = {pcen, ifen, if_flush, exen, flush, memen};

   localparam logic [5:0] C_RST  = 6'b001010;
   localparam logic [5:0] C_RUN  = 6'b110101;
   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_LU   = 6'b000111;
   localparam logic [5:0] C_BR   = 6'b111111;
   localparam logic [5:0] C_HLT  = 6'b000001;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ctl(input string tag, input logic [5:0] exp_c, input logic exp_h);
      #1;
      chk({tag, ".ctrl"}, {26'd0, ctrl_v}, {26'd0, exp_c});
      chk({tag, ".halted"}, {31'd0, halted}, {31'd0, exp_h});
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr();
      ihit = 1'b1; dhit = 1'b0;
      id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_regDst = '0; mem_regDst = '0;
      ex_dREN = 1'b0; mem_regWr = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
      mem_wdat = '0; br_taken = 1'b0; ex_halt = 1'b0;
   endtask

   initial begin
      nRST = 1'b0;
      clr();
      // Forwarding match held during reset must not reach the outputs.
      mem_regWr = 1'b1; mem_regDst = 5'd8; ex_rs = 5'd8; mem_wdat = 32'h1234_5678;
      repeat (2) tick();
      ctl("rst", C_RST, 1'b0);
      chk("rst.srcA", {31'd0, srcA}, 32'd0);
      chk("rst.forData", forData, 32'd0);
      nRST = 1'b1;
      ctl("rst_hold", C_RST, 1'b0);
      clr();
      tick();
      ctl("run0", C_RUN, 1'b0);
      chk("run0.srcAB", {30'd0, srcA, srcB}, 32'd0);

      ihit = 1'b0;
      ctl("no_ihit", C_NONE, 1'b0);
      ihit = 1'b1;

      // Load-use bubble then one LDSTALL cycle.
      ex_dREN = 1'b1; ex_regDst = 5'd5; id_rt = 5'd5;
      ctl("lu", C_LU, 1'b0);
      tick();
      clr();
      ctl("ldstall", C_RUN, 1'b0);
`ifdef HAZARD_STATS_EN
      chk("load_stall_cnt", load_stall_cnt, 32'd1);
`endif
      tick();
      ex_dREN = 1'b1; ex_regDst = 5'd0;
      ctl("lu_r0", C_RUN, 1'b0);
      clr();

      // Memory wait: 3 frozen cycles, resume on dhit.
      mem_dREN = 1'b1;
      ctl("mw1", C_NONE, 1'b0);
      tick();
      ctl("mw2", C_NONE, 1'b0);
      tick();
      ctl("mw3", C_NONE, 1'b0);
      tick();
      dhit = 1'b1;
      ctl("mw_dhit", C_RUN, 1'b0);
      tick();
      clr();
`ifdef HAZARD_STATS_EN
      // One LDSTALL cycle plus three MEMWAIT cycles.
      chk("stall_cnt", stall_cnt, 32'd4);
`endif

      // Forwarding.
      mem_regWr = 1'b1; mem_regDst = 5'd8; ex_rs = 5'd8; ex_rt = 5'd8; mem_wdat = 32'hDEAD_BEEF;
      #1;
      chk("fwd.srcAB", {30'd0, srcA, srcB}, 32'd3);
      chk("fwd.data", forData, 32'hDEAD_BEEF);
      mem_regDst = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
      #1;
      chk("fwd_r0.srcAB", {30'd0, srcA, srcB}, 32'd0);
      chk("fwd_r0.data", forData, 32'd0);
      mem_regDst = 5'd8; ex_rs = 5'd8; ex_rt = 5'd9;
      #1;
      chk("fwd_a.srcAB", {30'd0, srcA, srcB}, 32'd2);
      mem_dWEN = 1'b1; dhit = 1'b1;
      #1;
      chk("fwd_st.srcAB", {30'd0, srcA, srcB}, 32'd0);
      chk("fwd_st.data", forData, 32'd0);
      clr();

      // Branch without ihit must not flush.
      br_taken = 1'b1; ihit = 1'b0;
      ctl("br_noihit", C_NONE, 1'b0);
      tick();
      // Branch beats load-use.
      ihit = 1'b1; ex_dREN = 1'b1; ex_regDst = 5'd5; id_rt = 5'd5;
      ctl("br_lu", C_BR, 1'b0);
      tick();
      clr();
`ifdef HAZARD_STATS_EN
      chk("flush_cnt", flush_cnt, 32'd1);
      chk("load_stall_cnt2", load_stall_cnt, 32'd1);
`endif
      // Still in RUN (not LDSTALL): halt is honoured immediately.
      ex_halt = 1'b1;
      ctl("halt_req", C_HLT, 1'b0);
      tick();
      clr();
      ctl("halted", C_NONE, 1'b1);
      mem_dREN = 1'b1;
      repeat (2) tick();
      ctl("halted2", C_NONE, 1'b1);
`ifdef HAZARD_STATS_EN
      chk("stall_cnt_frozen", stall_cnt, 32'd4);
`endif
      clr();

      nRST = 1'b0;
      ctl("rst2", C_RST, 1'b0);
`ifdef HAZARD_STATS_EN
      chk("stall_cnt_rst", stall_cnt, 32'd0);
      chk("flush_cnt_rst", flush_cnt, 32'd0);
`endif
      tick();
      nRST = 1'b1;
      tick();
      ctl("run_after_rst", C_RUN, 1'b0);

      // Memory wait outranks halt.
      mem_dREN = 1'b1; ex_halt = 1'b1;
      ctl("mw_vs_halt", C_NONE, 1'b0);
      tick();
      dhit = 1'b1; ex_halt = 1'b0;
      ctl("mw_exit", C_RUN, 1'b0);
      tick();
      clr();
      ctl("run_final", C_RUN, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the latch-control and forwarding inputs of the execute stage.
- Drives flush/exen to the ID/EX latch, srcA/srcB/forData, and the enables and flushes of the other pipeline latches and the PC.
- Resolves load-use stalls, memory-wait freezes, taken-branch flushes and halt sequencing with a small registered FSM.

Parameters:
- REGW, 5, register-index width (matches regbits_t)
- WORDW, 32, data width (matches word_t)

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- id_rs  in  REGW  rs of instruction in decode
- id_rt  in  REGW  rt of instruction in decode
- ex_rs  in  REGW  rs of instruction in execute
- ex_rt  in  REGW  rt of instruction in execute
- ex_regDst  in  REGW  destination of instruction in execute
- ex_dREN  in  1  instruction in execute is a load
- mem_regDst  in  REGW  destination of instruction in memory stage
- mem_regWr  in  1  memory-stage instruction writes a register
- mem_dREN  in  1  memory-stage instruction is a load
- mem_dWEN  in  1  memory-stage instruction is a store
- mem_wdat  in  WORDW  result of memory-stage instruction (ALU result or load data)
- br_taken  in  1  branch/jump resolved taken in execute
- ex_halt  in  1  halt reached end of execute (halt_next)
- pcen  out  1  PC update enable
- ifen  out  1  IF/ID latch enable
- if_flush  out  1  IF/ID latch flush
- exen  out  1  ID/EX latch enable
- flush  out  1  ID/EX latch flush
- memen  out  1  EX/MEM latch enable
- srcA  out  1  execute operand A takes forData
- srcB  out  1  execute operand B takes forData
- forData  out  WORDW  forwarded value
- halted  out  1  pipeline frozen on halt

Behaviour:
- Reset (nRST low, asynchronous):
  - FSM goes to RUN.
  - All enables go to 0; if_flush=1, flush=1.
  - srcA=0, srcB=0, forData=0, halted=0.
  - Outputs hold these values until the first rising edge after nRST deasserts.
- States: RUN, LDSTALL, MEMWAIT, HALT. Control outputs are a combinational function of state and inputs; only the state is registered.
- memwait = (mem_dREN|mem_dWEN) & !dhit.
- RUN:
  - Default: pcen=ifen=exen=memen=ihit, with no flush.
  - memwait has the highest priority: all enables 0, go to MEMWAIT.
  - Else if halt is set (ex_halt & ihit): all enables 0, memen=1 for one cycle so the halt reaches memory, go to HALT.
  - Else if br_taken & ihit: if_flush=1 and flush=1 on this edge; branch wins over load-use.
  - Else if load-use (ex_dREN & ex_regDst!=0 & (ex_regDst==id_rs | ex_regDst==id_rt)) & ihit: pcen=ifen=0, flush=1 (bubble), exen=1, memen=1, go to LDSTALL.
- LDSTALL:
  - Lasts exactly one cycle; normal RUN enables apply.
  - Return to RUN.
  - memwait in this state has priority: go to MEMWAIT.
- MEMWAIT:
  - All enables 0, no flushes, until dhit.
  - On dhit: enables follow ihit and the state returns to RUN.
- HALT:
  - All enables 0, halted=1.
  - Left only by reset.
- Forwarding (combinational, any state):
  - srcA = mem_regWr & !mem_dWEN & mem_regDst!=0 & mem_regDst==ex_rs; srcB is the same with ex_rt.
  - forData = mem_wdat whenever srcA|srcB, else 0.
  - Register 0 is never forwarded.
- If ihit=0 and no other event applies, every latch holds. A flush is asserted only when ihit=1, so no instruction is lost.
- Simultaneous events, priority high to low: reset, memwait, halt, branch, load-use.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds three outputs:
  - stall_cnt (32): counts cycles in LDSTALL or MEMWAIT.
  - flush_cnt (32): counts taken-branch flushes.
  - load_stall_cnt (32): counts load-use bubbles.
- All counters are cleared by nRST, wrap at 2^32, and freeze in HALT.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Release reset with ihit=1, no hazards -> first cycle all enables 1, flush=0, srcA=srcB=0, halted=0.
- ex_dREN=1, ex_regDst=5, id_rt=5, ihit=1 -> one cycle pcen=ifen=0, flush=1; next cycle enables 1; with stats, load_stall_cnt=1.
- mem_dREN=1, dhit=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, resume on the dhit cycle; with stats, stall_cnt=3.
- mem_regWr=1, mem_regDst=8, ex_rs=8, ex_rt=8, mem_wdat=0xDEADBEEF -> srcA=srcB=1, forData=0xDEADBEEF; repeat with mem_regDst=0 -> srcA=srcB=0.
- br_taken=1 together with a load-use match, ihit=1 -> if_flush=1, flush=1, pcen=1, no LDSTALL entry.
- ex_halt=1, ihit=1 -> memen=1 for one cycle, then halted=1 and all enables stay 0 until nRST is pulsed low, after which the FSM is in RUN.
